alu_serial_cmd_rx: RTL
======================

Name: alu_serial_cmd_rx

Overview:
- Upstream receive stage of the serial ALU datapath.
- Deserialises the single-wire command stream into one parallel command word: operand B, operand A and op code.
- Recomputes the 4-bit command CRC (x^4+x+1) and classifies each command as OK / CRC error / data-count error / framing error.
- Hands each result to the ALU execute stage over a valid/ready handshake with a one-entry output buffer.

Parameters:
- CRC_INIT, 4'h0, CRC register value at the start of every command.
- DATA_PKTS, 8, data packets per command (B bytes 3..0, then A bytes 3..0); the op field and CRC width are fixed.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- sin  in  1  serial input, idle high, one bit per clk.
- cmd_valid  out  1  output buffer holds a command.
- cmd_ready  in  1  downstream accepts when cmd_valid && cmd_ready at a rising edge.
- cmd_b  out  32  operand B; first data byte received is bits [31:24].
- cmd_a  out  32  operand A; fifth data byte received is bits [31:24].
- cmd_op  out  3  op code from the control packet.
- cmd_crc  out  4  CRC field received in the control packet.
- cmd_status  out  2  00 OK, 01 CRC_ERR, 10 DATA_ERR, 11 FRAME_ERR.
- overrun  out  1  one-cycle pulse: a command completed while the buffer was full; that command is dropped.

Behaviour:
- Packet format (11 bits, one per clk): start=0, type (0 data, 1 ctl), 8 payload bits MSB first, stop=1.
- Control payload: {1'b0, op[2:0], crc[3:0]}.
- FSM states: IDLE, TYPE, PAYLOAD, STOP.
  - IDLE: sin=0 moves to TYPE; sin=1 stays in IDLE.
  - TYPE: latch the type bit, clear bit_cnt, go to PAYLOAD.
  - PAYLOAD: stay exactly 8 clks, shifting payload into an 8-bit register; go to STOP.
  - STOP: sample the stop bit, evaluate the packet, go to IDLE.
  - A new start bit is accepted on the clk directly after STOP, so back-to-back packets need no idle gap.
- Data packet with stop=1:
  - pkt_cnt < DATA_PKTS: store the byte at index pkt_cnt, then increment pkt_cnt.
  - pkt_cnt already at DATA_PKTS: set the overflow flag; pkt_cnt saturates.
- Serial CRC over the 68-bit message {B, A, 1'b1, op}, first bit = B[31]:
  - per bit: fb = crc[3]^bit; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - Data payload bits are fed as they arrive.
  - On a ctl packet, after its stop bit, feed 1'b1 then op[2:0] over the next 4 clks in a CHECK sub-phase. CHECK runs in parallel with IDLE/TYPE reception of the next packet and must not stall sin.
  - crc resets to CRC_INIT at the end of every command and on any error.
- Command completion (result available 5 clks after the ctl stop bit):
  - ctl stop=1, pkt_cnt==DATA_PKTS, no overflow: status is OK if the computed CRC equals the received crc, else CRC_ERR.
  - ctl stop=1 with pkt_cnt!=DATA_PKTS or overflow set: status DATA_ERR; CRC is ignored.
  - Any packet with stop=0: status FRAME_ERR, completed 1 clk after that stop bit. The packet's payload is discarded and the partial command is abandoned.
  - After every completion: pkt_cnt, overflow flag and crc are cleared.
  - For error completions, cmd_b, cmd_a, cmd_op and cmd_crc carry whatever is currently assembled; unreceived fields read 0.
- Output buffer:
  - On completion with cmd_valid=0 (or cmd_valid && cmd_ready in the same clk), load the buffer and set cmd_valid=1.
  - Outputs are stable while cmd_valid && !cmd_ready.
  - Completion while the buffer is held: pulse overrun; the buffer is unchanged.
- Reset values: cmd_valid=0, cmd_b=0, cmd_a=0, cmd_op=0, cmd_crc=0, cmd_status=0, overrun=0; FSM=IDLE, counters=0, crc=CRC_INIT.
- Reset mid-packet aborts silently with no completion. After release, reception resumes at the next falling sin seen in IDLE.

Test Plan:
- B=0, A=0, op=000, crc=4'b1011, cmd_ready=1 -> cmd_valid pulses with cmd_b=0, cmd_a=0, cmd_op=000, status=00.
- B=0, A=0, op=100, crc=4'b0111 -> status=00. Same frame with crc=4'b1011 -> status=01, cmd_crc=1011.
- B=32'h01020304, A=32'hFFFFFFFF, with the ctl packet sent after only 7 data packets -> status=10, cmd_b=32'h01020304, cmd_a=32'hFFFFFF00. A following valid command yields status=00.
- Stop bit 0 on the 3rd data packet -> status=11 one clk after that stop bit; the next 9 packets decode normally.
- cmd_ready=0 held while two valid commands arrive -> first command stays stable, overrun pulses once, second command is lost. Then cmd_ready=1 -> cmd_valid drops next clk.
- rst asserted during the PAYLOAD of the ctl packet -> all outputs 0 asynchronously and no cmd_valid. A full frame after release (B=0, A=0, op=000, crc=1011) -> status=00.

Source files
------------

// File: rtl/alu_serial_cmd_rx.sv
// Serial command receiver: deserialises B/A/op packets, recomputes the x^4+x+1 CRC,
// classifies the command and holds the result in a one-entry valid/ready buffer.
module alu_serial_cmd_rx #(
  parameter logic [3:0] CRC_INIT  = 4'h0,
  parameter int         DATA_PKTS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_b,
  output logic [31:0] cmd_a,
  output logic [2:0]  cmd_op,
  output logic [3:0]  cmd_crc,
  output logic [1:0]  cmd_status,
  output logic        overrun
);

  localparam int CNT_W = $clog2(DATA_PKTS + 1);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t           r_state;
  logic             r_type;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             r_ovf;
  logic [63:0]      r_data;
  logic [2:0]       r_op;
  logic [3:0]       r_crc_rx;
  logic [3:0]       r_crc;
  logic [3:0]       r_chk_crc;
  logic [2:0]       r_chk_cnt;
  logic             r_chk_derr;
  logic             r_done;
  logic [1:0]       r_done_st;

  logic [3:0]       w_chk_msg;
  logic             w_chk_bit;
  logic [3:0]       w_chk_fin;
  logic             w_full;
  logic [2:0]       w_slot;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  // The tail {1'b1, op} is folded into a separate register so the next command's
  // payload bits can start accumulating in r_crc while the check is still running.
  assign w_chk_msg = {1'b1, r_op};
  assign w_chk_bit = w_chk_msg[2'(r_chk_cnt - 3'd1)];
  assign w_chk_fin = crc_step(r_chk_crc, w_chk_bit);
  assign w_full    = (r_pkt_cnt == CNT_W'(DATA_PKTS));
  assign w_slot    = 3'd7 - r_pkt_cnt[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_type     <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_pkt_cnt  <= '0;
      r_ovf      <= 1'b0;
      r_data     <= 64'd0;
      r_op       <= 3'd0;
      r_crc_rx   <= 4'd0;
      r_crc      <= CRC_INIT;
      r_chk_crc  <= CRC_INIT;
      r_chk_cnt  <= 3'd0;
      r_chk_derr <= 1'b0;
      r_done     <= 1'b0;
      r_done_st  <= 2'b00;
    end else begin
      r_done <= 1'b0;
      if (r_done) begin
        r_pkt_cnt <= '0;
        r_ovf     <= 1'b0;
        r_data    <= 64'd0;
        r_op      <= 3'd0;
        r_crc_rx  <= 4'd0;
      end

      if (r_chk_cnt != 3'd0) begin
        r_chk_crc <= w_chk_fin;
        r_chk_cnt <= r_chk_cnt - 3'd1;
        if (r_chk_cnt == 3'd1) begin
          r_done    <= 1'b1;
          r_done_st <= r_chk_derr ? 2'b10 : ((w_chk_fin == r_crc_rx) ? 2'b00 : 2'b01);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (!sin) r_state <= S_TYPE;
        end
        S_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= 3'd0;
          r_state   <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          r_shift   <= {r_shift[6:0], sin};
          if (!r_type) r_crc <= crc_step(r_crc, sin);
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= S_STOP;
        end
        default: begin
          r_state <= S_IDLE;
          if (!sin) begin
            r_done    <= 1'b1;
            r_done_st <= 2'b11;
            r_crc     <= CRC_INIT;
          end else if (!r_type) begin
            if (!w_full) begin
              r_data[{w_slot, 3'b000} +: 8] <= r_shift;
              r_pkt_cnt                     <= r_pkt_cnt + CNT_W'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_op       <= r_shift[6:4];
            r_crc_rx   <= r_shift[3:0];
            r_chk_crc  <= r_crc;
            r_crc      <= CRC_INIT;
            r_chk_cnt  <= 3'd4;
            r_chk_derr <= !w_full || r_ovf;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid  <= 1'b0;
      cmd_b      <= 32'd0;
      cmd_a      <= 32'd0;
      cmd_op     <= 3'd0;
      cmd_crc    <= 4'd0;
      cmd_status <= 2'b00;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (r_done) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid  <= 1'b1;
          cmd_b      <= r_data[63:32];
          cmd_a      <= r_data[31:0];
          cmd_op     <= r_op;
          cmd_crc    <= r_crc_rx;
          cmd_status <= r_done_st;
        end else begin
          overrun <= 1'b1;
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
